ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
// - Shares one eight_bit_ram (8x8, 1-cycle registered read, wr_rd_en=1 write / 0 read) between two requesters A and B.
// - Round-robin arbitration, valid/ready request handshake, registered response pulse per accepted transaction.
// - Sits between requester logic and the RAM instance. Sole driver of the RAM's wr_rd_en/addr/data_in.
// - Top level drives the RAM's active-high rst from ~rst.
// PARAMETERS
// - DATA_W  8  data width; must match RAM
// - ADDR_W  3  address width; must match RAM (depth 2**ADDR_W)
// PORTS
// - clk          in   1       rising-edge clock
// - rst          in   1       synchronous, active-low reset
// - a_req_valid  in   1       A request present
// - a_req_ready  out  1       A request accepted this cycle when valid&ready
// - a_req_we     in   1       1=write, 0=read
// - a_req_addr   in   ADDR_W  A address
// - a_req_wdata  in   DATA_W  A write data
// - a_rsp_valid  out  1       one-cycle pulse: A transaction complete
// - a_rsp_rdata  out  DATA_W  A read data, valid with a_rsp_valid on reads
// - b_*          (same seven signals for requester B)
// - ram_wr_rd_en out  1       to RAM wr_rd_en
// - ram_addr     out  ADDR_W  to RAM addr
// - ram_data_in  out  DATA_W  to RAM data_in
// - ram_data_out in   DATA_W  from RAM data_out
// - busy         out  1       1 whenever state != IDLE
// BEHAVIOUR
// - Reset (rst==0 at posedge):
//   - state=IDLE, rr_last=B (A wins first tie).
//   - All ram_* regs 0. *_rsp_valid 0, *_rsp_rdata 0.
//   - An in-flight transaction is dropped without a response.
// - FSM: IDLE -> ACCESS -> (read) CAPTURE -> IDLE;  (write) ACCESS -> IDLE.
// - IDLE:
//   - *_req_ready is combinational, asserted only in IDLE, to exactly one requester.
//   - Only one requester valid: it wins. Both valid: the one != rr_last wins.
//   - On accept: register we/addr/wdata into ram_* regs, record owner, rr_last<=owner, go to ACCESS.
//   - rr_last is unchanged when nothing is accepted.
// - ACCESS (1 cycle): ram_wr_rd_en=we, ram_addr/ram_data_in stable.
//   - At the end edge: ram_wr_rd_en<=0.
//   - Write: owner rsp_valid<=1, go to IDLE.
//   - Read: go to CAPTURE.
// - CAPTURE (1 cycle): RAM data_out now holds mem[addr].
//   - At the end edge: owner rsp_rdata<=ram_data_out, owner rsp_valid<=1, go to IDLE.
// - Latency, accept cycle = C0:
//   - Write ack: rsp_valid high in C2.
//   - Read data: rsp_valid high in C3.
//   - New accept is possible in the same cycle as rsp_valid. Peak: 1 write/2 cycles, 1 read/3 cycles.
// - rsp_valid lasts exactly 1 cycle; there is no response backpressure.
// - rsp_rdata holds its last read value; it is not updated on writes.
// - Outside ACCESS, ram_wr_rd_en=0 (RAM reads harmlessly); ram_addr/ram_data_in hold last values.
// - Requester obligation: req_* stable while valid && !ready. The arbiter does not check this.
// - Boundaries:
//   - Both requesters valid on every cycle: grants strictly alternate.
//   - Address 2**ADDR_W-1 has no wrap logic; the full address is passed through.
//   - A and B may target the same address: accept order defines RAM order.
//   - A read accepted after a write to the same address returns the new data.
//   - rst low during ACCESS of a write: the RAM still writes (its write enable is already registered high); no ack is given.
// STRUCTURE
// - Package ram_arb_pkg:
//   - typedef enum {IDLE, ACCESS, CAPTURE} arb_state_t
//   - typedef enum {OWN_A, OWN_B} owner_t
//   - localparams DATA_W/ADDR_W defaults
// - Sub-module rr_arb2: 2-way round-robin grant.
//   - Inputs: req[1:0], rr_last, en. Output: one-hot gnt.
//   - Purely combinational; rr_last register lives in the parent.
// TESTING
// - Reset then A write addr3=0xA5 alone:
//   - a_req_ready in C0; ram_wr_rd_en=1, ram_addr=3 in C1; a_rsp_valid in C2.
// - A read addr3 after that write:
//   - a_rsp_valid in C3 with a_rsp_rdata=0xA5; b_rsp_valid stays 0.
// - A and B both valid continuously from reset, B reads addr0-7, A writes 0x10+i:
//   - grant order A,B,A,B...
//   - no cycle with both req_ready high; every rsp routed to its own owner.
// - B write addr7=0xFF and A read addr7 raised together:
//   - B first (rr_last=A from the previous grant), then A read returns 0xFF.
// - rst low during CAPTURE of an A read:
//   - no a_rsp_valid; next cycle state IDLE, busy=0, ram_wr_rd_en=0, rr_last=B.
// - A valid held, then dropped before grant while B busy:
//   - no spurious accept; rr_last unchanged; back-to-back A-only writes give rsp_valid every 2 cycles.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-requester RAM port arbiter.
// Imported by rr_arb2 and ram_port_arbiter.
package ram_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    // Bit 0 of a grant vector is requester A, bit 1 is requester B.
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// The previous winner (rr_last) is held by the parent.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (owner_t'(rr_last) == OWN_B) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM (1-cycle registered read) between requesters A and B,
// with round-robin acceptance and a one-cycle response pulse per transaction.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic              ram_wr_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,

    output logic              busy
);

    arb_state_t        state_q,       state_d;
    owner_t            owner_q,       owner_d;
    owner_t            rr_last_q,     rr_last_d;
    logic              ram_we_q,      ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,    ram_addr_d;
    logic [DATA_W-1:0] ram_data_q,    ram_data_d;
    logic              a_rsp_valid_q, a_rsp_valid_d;
    logic              b_rsp_valid_q, b_rsp_valid_d;
    logic [DATA_W-1:0] a_rsp_rdata_q, a_rsp_rdata_d;
    logic [DATA_W-1:0] b_rsp_rdata_q, b_rsp_rdata_d;
    logic [1:0]        gnt;

    rr_arb2 u_rr_arb2 (
        .req     ({b_req_valid, a_req_valid}),
        .rr_last (rr_last_q),
        .en      (state_q == IDLE),
        .gnt     (gnt)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_last_d     = rr_last_q;
        ram_we_d      = ram_we_q;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        a_rsp_valid_d = 1'b0;
        b_rsp_valid_d = 1'b0;
        a_rsp_rdata_d = a_rsp_rdata_q;
        b_rsp_rdata_d = b_rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d    = gnt[1] ? OWN_B : OWN_A;
                    rr_last_d  = owner_d;
                    ram_we_d   = gnt[1] ? b_req_we    : a_req_we;
                    ram_addr_d = gnt[1] ? b_req_addr  : a_req_addr;
                    ram_data_d = gnt[1] ? b_req_wdata : a_req_wdata;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // The RAM commits the write (or registers the read) on this cycle's closing edge.
                ram_we_d = 1'b0;
                if (ram_we_q) begin
                    a_rsp_valid_d = (owner_q == OWN_A);
                    b_rsp_valid_d = (owner_q == OWN_B);
                    state_d       = IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (owner_q == OWN_A) begin
                    a_rsp_rdata_d = ram_data_out;
                    a_rsp_valid_d = 1'b1;
                end else begin
                    b_rsp_rdata_d = ram_data_out;
                    b_rsp_valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (!rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_A;
            rr_last_q     <= OWN_B;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            a_rsp_rdata_q <= '0;
            b_rsp_rdata_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_last_q     <= rr_last_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            a_rsp_valid_q <= a_rsp_valid_d;
            b_rsp_valid_q <= b_rsp_valid_d;
            a_rsp_rdata_q <= a_rsp_rdata_d;
            b_rsp_rdata_q <= b_rsp_rdata_d;
        end
    end

    assign a_req_ready  = gnt[0];
    assign b_req_ready  = gnt[1];
    assign a_rsp_valid  = a_rsp_valid_q;
    assign b_rsp_valid  = b_rsp_valid_q;
    assign a_rsp_rdata  = a_rsp_rdata_q;
    assign b_rsp_rdata  = b_rsp_rdata_q;
    assign ram_wr_rd_en = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_data_in  = ram_data_q;
    assign busy         = (state_q != IDLE);

endmodule
